// File: rtl/elevator_ctrl_n.sv
// N-floor elevator car controller.
// Serves latched calls in SCAN order and sequences the door.
module elevator_ctrl_n #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS),
  parameter int T_DOOR     = 2,
  parameter int T_WAIT     = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  arrived,
  input  logic                  door_hold,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic [NUM_FLOORS-1:0] floor_led,
  output logic [1:0]            dir,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPENING,
    DOOR_DWELL,
    DOOR_CLOSING
  } state_e;

  localparam logic [CNT_W-1:0]   DOOR_LD = CNT_W'(T_DOOR);
  localparam logic [CNT_W-1:0]   WAIT_LD = CNT_W'(T_WAIT);
  localparam logic [FLOOR_W-1:0] TOP     = FLOOR_W'(NUM_FLOORS - 1);

  state_e                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic [NUM_FLOORS-1:0]   pend_q, pend_d;
  logic [NUM_FLOORS-1:0]   clr_mask, cur_oh;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pref_up_q, pref_up_d;
  logic                    above, below, here, call_here;
  logic                    next_up_hit, next_dn_hit;
  logic                    at_top, at_bot, cnt_done;

  always_comb begin
    above  = 1'b0;
    below  = 1'b0;
    cur_oh = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      cur_oh[i] = (FLOOR_W'(i) == floor_q);
      if (FLOOR_W'(i) > floor_q) above = above | pend_q[i];
      if (FLOOR_W'(i) < floor_q) below = below | pend_q[i];
    end
  end

  // Shifted one-hot looks at the neighbour floor without out-of-range indexing.
  assign here        = |(pend_q & cur_oh);
  assign call_here   = |(call_req & cur_oh);
  assign next_up_hit = |(pend_q & (cur_oh << 1));
  assign next_dn_hit = |(pend_q & (cur_oh >> 1));
  assign at_top      = (floor_q == TOP);
  assign at_bot      = (floor_q == '0);
  assign cnt_done    = (cnt_q <= CNT_W'(1));
  assign pend_d      = (pend_q | call_req) & ~clr_mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      pend_q    <= '0;
      cnt_q     <= '0;
      pref_up_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      pref_up_q <= pref_up_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    cnt_d     = cnt_q;
    pref_up_d = pref_up_q;
    unique case (state_q)
      IDLE: begin
        if (here) begin
          state_d = DOOR_OPENING;
          cnt_d   = DOOR_LD;
        end else if (above && (pref_up_q || !below)) begin
          state_d = MOVE_UP;
        end else if (below) begin
          state_d = MOVE_DOWN;
        end
      end
      MOVE_UP: begin
        if (arrived && !at_top) begin
          floor_d   = floor_q + FLOOR_W'(1);
          pref_up_d = 1'b1;
          if (next_up_hit) begin
            state_d = DOOR_OPENING;
            cnt_d   = DOOR_LD;
          end
        end
      end
      MOVE_DOWN: begin
        if (arrived && !at_bot) begin
          floor_d   = floor_q - FLOOR_W'(1);
          pref_up_d = 1'b0;
          if (next_dn_hit) begin
            state_d = DOOR_OPENING;
            cnt_d   = DOOR_LD;
          end
        end
      end
      DOOR_OPENING: begin
        if (cnt_done) begin
          state_d = DOOR_DWELL;
          cnt_d   = WAIT_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DOOR_DWELL: begin
        if (door_hold || call_here) begin
          cnt_d = WAIT_LD;
        end else if (cnt_done) begin
          state_d = DOOR_CLOSING;
          cnt_d   = DOOR_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DOOR_CLOSING: begin
        if (door_hold || call_here) begin
          state_d = DOOR_OPENING;
          cnt_d   = DOOR_LD;
        end else if (cnt_done) begin
          cnt_d = '0;
          if (pref_up_q) begin
            if (above)      state_d = MOVE_UP;
            else if (below) state_d = MOVE_DOWN;
            else            state_d = IDLE;
          end else begin
            if (below)      state_d = MOVE_DOWN;
            else if (above) state_d = MOVE_UP;
            else            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serviced-floor calls are absorbed only while the door is opening or open.
  always_comb begin
    dir       = 2'b00;
    door_open = 1'b0;
    clr_mask  = '0;
    unique case (state_q)
      MOVE_UP:   dir = 2'b01;
      MOVE_DOWN: dir = 2'b10;
      DOOR_OPENING, DOOR_DWELL: begin
        door_open = 1'b1;
        clr_mask  = cur_oh;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign cur_floor = floor_q;
  assign floor_led = cur_oh;
  assign pending   = pend_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Bench for elevator_ctrl_n: door-open scoreboard of served floors
// plus directed timing checks.
module tb_elevator_ctrl_n;

  localparam int NF = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] call_req;
  logic          arrived;
  logic          door_hold;
  logic [2:0]    cur_floor;
  logic [NF-1:0] floor_led;
  logic [1:0]    dir;
  logic          door_open;
  logic [NF-1:0] pending;
  logic          busy;

  int   n_total = 0;
  int   n_bad   = 0;
  int   exp_q[$];
  logic door_prev;
  logic auto_drv;
  int   drv_cnt;
  int   n;

  elevator_ctrl_n #(
    .NUM_FLOORS(NF),
    .FLOOR_W(3),
    .T_DOOR(2),
    .T_WAIT(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .call_req(call_req),
    .arrived(arrived),
    .door_hold(door_hold),
    .cur_floor(cur_floor),
    .floor_led(floor_led),
    .dir(dir),
    .door_open(door_open),
    .pending(pending),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // One clock: sample after the edge, score door openings, model the drive.
  task automatic tick();
    @(posedge clk);
    #1;
    if (door_open && !door_prev) begin
      if (exp_q.size() == 0)
        chk("sb_extra_open", 32'(exp_q.size()), 32'd1);
      else
        chk("sb_serve", 32'(cur_floor), 32'(exp_q.pop_front()));
    end
    door_prev = door_open;
    arrived   = 1'b0;
    if (auto_drv && dir != 2'b00) begin
      drv_cnt++;
      if (drv_cnt == 3) begin
        arrived = 1'b1;
        drv_cnt = 0;
      end
    end else begin
      drv_cnt = 0;
    end
  endtask

  task automatic wait_floor(input int f, input string tag);
    int k = 0;
    while (32'(cur_floor) != f && k < 100) begin
      tick();
      k++;
    end
    chk(tag, 32'(cur_floor), 32'(f));
  endtask

  task automatic wait_door(input logic v, input string tag);
    int k = 0;
    while (door_open !== v && k < 100) begin
      tick();
      k++;
    end
    chk(tag, 32'(door_open), 32'(v));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic count_open(output int cnt);
    cnt = 1;
    while (door_open && cnt < 40) begin
      tick();
      if (door_open) cnt++;
    end
  endtask

  initial begin
    rst       = 1'b0;
    call_req  = '0;
    arrived   = 1'b0;
    door_hold = 1'b0;
    auto_drv  = 1'b0;
    door_prev = 1'b0;
    drv_cnt   = 0;
    #12;
    chk("rst_floor", 32'(cur_floor), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_door", 32'(door_open), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick();
    tick();
    auto_drv = 1'b1;

    // reset in the middle of an upward trip
    call_req = 8'h80;
    exp_q.push_back(7);
    tick();
    call_req = '0;
    wait_floor(2, "t1_floor2");
    chk("t1_moving", 32'(dir), 32'd1);
    rst = 1'b0;
    #1;
    chk("t1_floor", 32'(cur_floor), 32'd0);
    chk("t1_dir", 32'(dir), 32'd0);
    chk("t1_door", 32'(door_open), 32'd0);
    chk("t1_pend", 32'(pending), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_led", 32'(floor_led), 32'h01);
    exp_q.delete();
    door_prev = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    chk("t1_idle", 32'(busy), 32'd0);

    // single trip 0 -> 4
    call_req = 8'h10;
    exp_q.push_back(4);
    tick();
    chk("t2_dir_c1", 32'(dir), 32'd0);
    call_req = '0;
    tick();
    chk("t2_dir_c2", 32'(dir), 32'd1);
    for (int f = 1; f <= 4; f++) wait_floor(f, "t2_step");
    chk("t2_door_at4", 32'(door_open), 32'd1);
    chk("t2_led", 32'(floor_led), 32'h10);
    count_open(n);
    chk("t2_open_len", 32'(n), 32'd6);
    chk("t2_pend4", 32'(pending[4]), 32'd0);
    tick();
    chk("t2_busy_c1", 32'(busy), 32'd1);
    tick();
    chk("t2_idle_c2", 32'(busy), 32'd0);

    // call at the current floor in IDLE: no motion
    call_req = 8'h10;
    exp_q.push_back(4);
    tick();
    call_req = '0;
    chk("t6_nomove_c1", 32'(dir), 32'd0);
    tick();
    chk("t6_open_here", 32'(door_open), 32'd1);
    chk("t6_nomove_c2", 32'(dir), 32'd0);

    // reopen on a call in the first closing cycle
    wait_door(1'b0, "t4_closing");
    call_req = 8'h10;
    exp_q.push_back(4);
    tick();
    call_req = '0;
    chk("t4_reopen", 32'(door_open), 32'd1);
    count_open(n);
    chk("t4_open_len", 32'(n), 32'd6);
    wait_idle("t4_idle");

    // door hold during dwell
    call_req = 8'h10;
    exp_q.push_back(4);
    tick();
    call_req = '0;
    tick();
    tick();
    tick();
    door_hold = 1'b1;
    n = 0;
    repeat (10) begin
      tick();
      if (!door_open) n++;
    end
    door_hold = 1'b0;
    chk("t5_held", 32'(n), 32'd0);
    n = 0;
    while (door_open && n < 20) begin
      tick();
      n++;
    end
    chk("t5_after", 32'(n), 32'd4);
    wait_idle("t5_idle");

    // SCAN: at floor 3 going up with calls at 0 and 7
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    call_req = 8'h80;
    exp_q.push_back(7);
    tick();
    call_req = '0;
    wait_floor(3, "t3_at3");
    chk("t3_up", 32'(dir), 32'd1);
    call_req = 8'h01;
    exp_q.push_back(0);
    tick();
    call_req = '0;
    chk("t3_pend", 32'(pending), 32'h81);
    wait_floor(7, "t3_at7");
    arrived = 1'b1;
    tick();
    chk("t6_top_hold", 32'(cur_floor), 32'd7);
    wait_door(1'b0, "t3_close7");
    tick();
    tick();
    chk("t3_dir_down", 32'(dir), 32'd2);
    wait_floor(0, "t3_at0");
    chk("t3_open0", 32'(door_open), 32'd1);
    wait_door(1'b0, "t3_close0");
    wait_idle("t3_idle");
    chk("sb_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
